alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_alu_sequencer.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Queues operation requests and issues them one at a time to a downstream
// combinational ALU. Each issued operation holds its operands on the ALU
// inputs for SETTLE_CYCLES edges, then captures the ALU result and error flag
// and presents them on a valid/ready result port until taken.
//
// Parameters
//   SETTLE_CYCLES  edges operands are held before result capture (1..15)
//   FIFO_DEPTH     operation queue entries (power of two, 2..16)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   opValid/opReady            operation request handshake (opReady = not full)
//   opA, opB, opCmd            requested operands and command code
//   aluA, aluB, aluCmd         registered drive to the downstream ALU
//   aluResult, aluError        ALU result and overflow flag
//   resValid/resReady          result handshake
//   resData, resError, resCmd  captured result, error flag, echoed command
//   busy                       FSM not idle or queue non-empty
//   stickyError                accumulated error status
//
// Build option
//   ALU_SEQ_STICKY_ERR_EN  when defined, stickyError sets on every result
//                          transfer that carries resError and clears only on
//                          reset; when undefined stickyError is tied low.
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int SETTLE_CYCLES = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        opValid,
    output logic        opReady,
    input  logic [15:0] opA,
    input  logic [15:0] opB,
    input  logic [3:0]  opCmd,
    output logic [15:0] aluA,
    output logic [15:0] aluB,
    output logic [3:0]  aluCmd,
    input  logic [31:0] aluResult,
    input  logic        aluError,
    output logic        resValid,
    input  logic        resReady,
    output logic [31:0] resData,
    output logic        resError,
    output logic [3:0]  resCmd,
    output logic        busy,
    output logic        stickyError
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(FIFO_DEPTH);
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    // state  | meaning
    // IDLE   | no operation executing; pops the queue head when one exists
    // SETTLE | operands driven to the ALU, settle counter running down
    // DONE   | result captured and presented, waiting for resReady
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Queue entry layout: {cmd[3:0], a[15:0], b[15:0]}
    logic [35:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [35:0]      head;

    logic [3:0] settle_cnt;
    logic       push;
    logic       pop;
    logic       capture;

    assign push       = opValid && opReady;
    assign head       = fifo_mem[rd_ptr];
    assign count_next = count + CNT_W'(push) - CNT_W'(pop);

    // -------------------------------------------------------------------------
    // FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (resReady) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Operation queue
    // -------------------------------------------------------------------------
    // Storage carries no reset: occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {opCmd, opA, opB};
        end
    end

    // opReady is a flop loaded from the next occupancy, so it reflects
    // not-full of the current count without any same-cycle path from pop.
    // It is held low through reset and rises on the first edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            opReady <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count   <= count_next;
            opReady <= (count_next != CNT_FULL);
        end
    end

    // -------------------------------------------------------------------------
    // ALU drive, settle timer and result capture
    // -------------------------------------------------------------------------
    // ALU operands change only on a pop, so they stay stable through SETTLE,
    // DONE and the following IDLE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aluA       <= '0;
            aluB       <= '0;
            aluCmd     <= '0;
            settle_cnt <= '0;
            resData    <= '0;
            resError   <= 1'b0;
            resCmd     <= '0;
        end else begin
            if (pop) begin
                aluCmd     <= head[35:32];
                aluA       <= head[31:16];
                aluB       <= head[15:0];
                settle_cnt <= SETTLE_LOAD;
            end else if (state == SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end
            if (capture) begin
                resData  <= aluResult;
                resError <= aluError;
                resCmd   <= aluCmd;
            end
        end
    end

    assign resValid = (state == DONE);
    assign busy     = (state != IDLE) || (count != '0);

    // -------------------------------------------------------------------------
    // Sticky error status
    // -------------------------------------------------------------------------
`ifdef ALU_SEQ_STICKY_ERR_EN
    logic sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (state == DONE && resReady && resError) begin
            sticky_q <= 1'b1;
        end
    end

    assign stickyError = sticky_q;
`else
    assign stickyError = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        opValid;
    logic        opReady;
    logic [15:0] opA;
    logic [15:0] opB;
    logic [3:0]  opCmd;
    logic [15:0] aluA;
    logic [15:0] aluB;
    logic [3:0]  aluCmd;
    logic [31:0] aluResult;
    logic        aluError;
    logic        resValid;
    logic        resReady;
    logic [31:0] resData;
    logic        resError;
    logic [3:0]  resCmd;
    logic        busy;
    logic        stickyError;

    logic [31:0] alu_perturb;
    logic        err_perturb;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic [3:0]  cmd;
    } exp_t;

    exp_t sb[$];

`ifdef ALU_SEQ_STICKY_ERR_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_sequencer #(.SETTLE_CYCLES(2), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .opValid(opValid), .opReady(opReady),
        .opA(opA), .opB(opB), .opCmd(opCmd),
        .aluA(aluA), .aluB(aluB), .aluCmd(aluCmd),
        .aluResult(aluResult), .aluError(aluError),
        .resValid(resValid), .resReady(resReady),
        .resData(resData), .resError(resError), .resCmd(resCmd),
        .busy(busy), .stickyError(stickyError)
    );

    // Team 16-bit ALU: 1 add, 2 sub, 3 mul (signed). Overflow on add/sub when
    // the result leaves the 16-bit signed range. Other codes return a fixed
    // pattern of the operands so command passthrough is observable.
    function automatic logic [32:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                              input logic [3:0] c);
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        logic signed [31:0] r;
        logic               e;
        sa  = {{16{a[15]}}, a};
        sbv = {{16{b[15]}}, b};
        r   = '0;
        e   = 1'b0;
        case (c)
            4'd1: begin
                r = sa + sbv;
                e = (r > 32'sd32767) || (r < -32'sd32768);
            end
            4'd2: begin
                r = sa - sbv;
                e = (r > 32'sd32767) || (r < -32'sd32768);
            end
            4'd3: r = sa * sbv;
            default: r = {a, b} ^ {28'h0, c};
        endcase
        return {e, r};
    endfunction

    logic [32:0] alu_out;
    always_comb begin
        alu_out   = alu_model(aluA, aluB, aluCmd);
        aluResult = alu_out[31:0] ^ alu_perturb;
        aluError  = alu_out[32] ^ err_perturb;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] c);
        logic [32:0] m;
        exp_t        e;
        int          n;
        n       = 0;
        opValid = 1'b1;
        opA     = a;
        opB     = b;
        opCmd   = c;
        while (!opReady && n < 50) begin
            tick();
            n++;
        end
        if (!opReady) begin
            total++;
            bad++;
            $display("FAIL push_timeout: opReady=%b required 1", opReady);
        end
        tick();
        opValid = 1'b0;
        m      = alu_model(a, b, c);
        e.data = m[31:0];
        e.err  = m[32];
        e.cmd  = c;
        sb.push_back(e);
    endtask

    task automatic wait_valid(input int max, output bit ok);
        int n;
        n = 0;
        while (!resValid && n < max) begin
            tick();
            n++;
        end
        ok = resValid;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        opValid     = 1'b0;
        opA         = '0;
        opB         = '0;
        opCmd       = '0;
        resReady    = 1'b0;
        alu_perturb = '0;
        err_perturb = 1'b0;
        repeat (3) tick();
        total++;
        if ({opReady, resValid, busy, stickyError} !== 4'b0) begin
            bad++;
            $display("FAIL reset_flags: opReady/resValid/busy/sticky=%b required 0000",
                     {opReady, resValid, busy, stickyError});
        end
        total++;
        if ({resData, resError, resCmd} !== 37'h0) begin
            bad++;
            $display("FAIL reset_result: data=%h err=%b cmd=%h required all 0", resData, resError, resCmd);
        end
        total++;
        if ({aluA, aluB, aluCmd} !== 36'h0) begin
            bad++;
            $display("FAIL reset_alu: a=%h b=%h cmd=%h required all 0", aluA, aluB, aluCmd);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (opReady !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready_early: opReady=%b required 0 before first edge", opReady);
        end
        tick();
        total++;
        if (opReady !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready_rise: opReady=%b required 1", opReady);
        end
    endtask

    task automatic test_single();
        logic [2:0] rv;
        exp_t       e;
        resReady = 1'b1;
        push_op(16'd249, 16'd69, 4'd1);
        rv = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            rv[i] = resValid;
            if (i == 0) begin
                total++;
                if ({aluA, aluB, aluCmd} !== {16'd249, 16'd69, 4'd1}) begin
                    bad++;
                    $display("FAIL single_alu_drive: a=%0d b=%0d cmd=%0d required 249 69 1", aluA, aluB, aluCmd);
                end
            end
        end
        total++;
        if (rv !== 3'b100) begin
            bad++;
            $display("FAIL single_latency: resValid per edge=%b required 100", rv);
        end
        e = sb.pop_front();
        total++;
        if ({resData, resError, resCmd} !== {32'd318, 1'b0, 4'd1} ||
            {resData, resError, resCmd} !== {e.data, e.err, e.cmd}) begin
            bad++;
            $display("FAIL single_result: data=%0d err=%b cmd=%0d required 318 0 1", resData, resError, resCmd);
        end
        tick();
        total++;
        if ({resValid, busy} !== 2'b00) begin
            bad++;
            $display("FAIL single_after: resValid/busy=%b required 00", {resValid, busy});
        end
    endtask

    task automatic test_back_to_back();
        bit   ok;
        exp_t e;
        resReady = 1'b1;
        push_op(16'd249, 16'd69, 4'd2);
        push_op(16'd249, 16'd69, 4'd3);
        push_op(16'hA5A5, 16'h0F0F, 4'd0);
        push_op(16'h1234, 16'h5678, 4'd9);
        for (int i = 0; i < 4; i++) begin
            wait_valid(40, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL b2b_timeout[%0d]: resValid=%b required 1", i, resValid);
            end
            e = sb.pop_front();
            total++;
            if ({resData, resError, resCmd} !== {e.data, e.err, e.cmd}) begin
                bad++;
                $display("FAIL b2b_result[%0d]: data=%0d err=%b cmd=%0d required %0d %b %0d",
                         i, resData, resError, resCmd, e.data, e.err, e.cmd);
            end
            tick();
            total++;
            if (resValid !== 1'b0) begin
                bad++;
                $display("FAIL b2b_gap[%0d]: resValid=%b required 0", i, resValid);
            end
        end
    endtask

    task automatic test_full();
        int          accepted;
        bit          ok;
        exp_t        e;
        logic [32:0] m;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  c;
        resReady = 1'b0;
        accepted = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            a       = 16'(1000 * accepted + 7);
            b       = 16'(13 * accepted + 3);
            c       = 4'(accepted % 3 + 1);
            opValid = (accepted < 6);
            opA     = a;
            opB     = b;
            opCmd   = c;
            if (opValid && opReady) begin
                m      = alu_model(a, b, c);
                e.data = m[31:0];
                e.err  = m[32];
                e.cmd  = c;
                sb.push_back(e);
                accepted++;
            end
            tick();
        end
        opValid = 1'b0;
        total++;
        if (accepted != 5) begin
            bad++;
            $display("FAIL full_accepted: accepted=%0d required 5", accepted);
        end
        total++;
        if ({opReady, busy} !== 2'b01) begin
            bad++;
            $display("FAIL full_ready: opReady/busy=%b required 01", {opReady, busy});
        end
        resReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_valid(40, ok);
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL full_timeout[%0d]: resValid=%b required 1", i, resValid);
            end
            if (sb.size() > 0) e = sb.pop_front();
            total++;
            if ({resData, resError, resCmd} !== {e.data, e.err, e.cmd}) begin
                bad++;
                $display("FAIL full_result[%0d]: data=%0d err=%b cmd=%0d required %0d %b %0d",
                         i, resData, resError, resCmd, e.data, e.err, e.cmd);
            end
            tick();
            if (i == 0) begin
                tick();
                total++;
                if (opReady !== 1'b1) begin
                    bad++;
                    $display("FAIL full_ready_return: opReady=%b required 1", opReady);
                end
            end
        end
    endtask

    task automatic test_error_sticky();
        bit   ok;
        exp_t e;
        resReady = 1'b1;
        total++;
        if (stickyError !== 1'b0) begin
            bad++;
            $display("FAIL sticky_pre: stickyError=%b required 0", stickyError);
        end
        push_op(16'd32000, 16'd16001, 4'd1);
        wait_valid(40, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL err_timeout: resValid=%b required 1", resValid);
        end
        e = sb.pop_front();
        total++;
        if ({resData, resError, resCmd} !== {e.data, 1'b1, 4'd1} || e.err !== 1'b1) begin
            bad++;
            $display("FAIL err_result: data=%0d err=%b cmd=%0d required %0d 1 1", resData, resError, resCmd, e.data);
        end
        tick();
        total++;
        if (stickyError !== STICKY_ON) begin
            bad++;
            $display("FAIL sticky_set: stickyError=%b required %b", stickyError, STICKY_ON);
        end
        push_op(16'd5, 16'd6, 4'd1);
        wait_valid(40, ok);
        e = sb.pop_front();
        total++;
        if (!ok || {resData, resError, resCmd} !== {32'd11, 1'b0, 4'd1}) begin
            bad++;
            $display("FAIL err_clean_result: valid=%b data=%0d err=%b required 1 11 0", ok, resData, resError);
        end
        tick();
        total++;
        if (stickyError !== STICKY_ON) begin
            bad++;
            $display("FAIL sticky_hold: stickyError=%b required %b", stickyError, STICKY_ON);
        end
    endtask

    task automatic test_hold();
        bit   ok;
        exp_t e;
        resReady = 1'b0;
        push_op(16'd1234, 16'd4321, 4'd3);
        wait_valid(40, ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL hold_timeout: resValid=%b required 1", resValid);
        end
        e = sb.pop_front();
        for (int i = 0; i < 10; i++) begin
            alu_perturb = $urandom() | 32'h1;
            err_perturb = ~err_perturb;
            tick();
            total++;
            if (resValid !== 1'b1 || {resData, resError, resCmd} !== {e.data, e.err, e.cmd} ||
                {aluA, aluB, aluCmd} !== {16'd1234, 16'd4321, 4'd3}) begin
                bad++;
                $display("FAIL hold_stable[%0d]: valid=%b data=%0d err=%b cmd=%0d required 1 %0d %b %0d",
                         i, resValid, resData, resError, resCmd, e.data, e.err, e.cmd);
            end
        end
        alu_perturb = '0;
        err_perturb = 1'b0;
        resReady    = 1'b1;
        tick();
        total++;
        if (resValid !== 1'b0) begin
            bad++;
            $display("FAIL hold_release: resValid=%b required 0", resValid);
        end
    endtask

    task automatic test_reset_mid();
        bit   ok;
        bit   saw_valid;
        exp_t e;
        resReady = 1'b1;
        push_op(16'd10, 16'd20, 4'd1);
        push_op(16'd30, 16'd40, 4'd2);
        push_op(16'd50, 16'd60, 4'd3);
        rst_n = 1'b0;
        #1;
        sb.delete();
        total++;
        if ({opReady, resValid, busy, stickyError} !== 4'b0 ||
            {resData, resError, resCmd} !== 37'h0 || {aluA, aluB, aluCmd} !== 36'h0) begin
            bad++;
            $display("FAIL midreset_outputs: flags=%b data=%h err=%b cmd=%h a=%h b=%h acmd=%h required all 0",
                     {opReady, resValid, busy, stickyError}, resData, resError, resCmd, aluA, aluB, aluCmd);
        end
        tick();
        tick();
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (resValid) saw_valid = 1'b1;
        end
        total++;
        if (saw_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_discard: saw_valid=%b busy=%b required 0 0", saw_valid, busy);
        end
        push_op(16'd77, 16'd88, 4'd2);
        wait_valid(40, ok);
        e = sb.pop_front();
        total++;
        if (!ok || {resData, resError, resCmd} !== {e.data, e.err, e.cmd}) begin
            bad++;
            $display("FAIL midreset_new_op: valid=%b data=%0d err=%b cmd=%0d required 1 %0d %b %0d",
                     ok, resData, resError, resCmd, e.data, e.err, e.cmd);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_error_sticky();
        test_hold();
        test_reset_mid();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_empty: entries=%0d required 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
